// File: rtl/therm_pkg.sv
// Shared constants, FSM encoding and parameter sanity helper for the
// thermistor ADC acquisition path.
package therm_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_ACCUM    = 3'd4,
    ST_WAIT     = 3'd5
  } state_e;

  // One conversion keeps CS_n low for 34 divider phases, plus a few cycles of slack.
  function automatic int min_sample_period(input int clk_div);
    return 34 * clk_div + 4;
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// Serial receiver for one 16-bit ADC frame: SCLK divider, bit counter and
// MSB-first shift register. SCLK idles high; data is captured on SCLK rise.
module spi_frame_rx
  import therm_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  miso_i,
  output logic                  sclk_o,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] frame_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic                  active_q, active_d;
  logic                  sclk_q, sclk_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;

  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    done_o   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      div_d    = DIV_LAST;
      bit_d    = '0;
    end else if (active_q) begin
      div_d = div_q - 1'b1;
      if (div_q == '0) begin
        div_d = DIV_LAST;
        if (!sclk_q) begin
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[FRAME_BITS-2:0], miso_i};
        end else if (bit_q == BIT_LAST) begin
          // done fires at the end of the last high phase; SCLK stays high
          active_d = 1'b0;
          done_o   = 1'b1;
        end else begin
          sclk_d = 1'b0;
          bit_d  = bit_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign frame_o = shreg_q;

endmodule

// File: rtl/therm_adc_reader.sv
// Thermistor ADC front end: periodic serial conversions, leading-bit check and
// 2^AVG_LOG2 averaging into v_therm with a one-cycle valid strobe.
module therm_adc_reader
  import therm_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int ADC_BITS      = 12,
  parameter int AVG_LOG2      = 2,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  output logic                adc_cs_n_o,
  output logic                adc_sclk_o,
  input  logic                adc_miso_i,
  output logic [ADC_BITS-1:0] v_therm_o,
  output logic                v_valid_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  // States: IDLE off | CS_SETUP cs low, pre-clock | SHIFT 16 sclk | CS_HOLD post-clock | ACCUM add or reject | WAIT period timer
  localparam int ACC_W = ADC_BITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TW    = $clog2(SAMPLE_PERIOD);
  localparam int PW    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
  localparam logic [TW-1:0]    T_LAST   = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0]    PH_LAST  = PW'(CLK_DIV - 1);

  if (SAMPLE_PERIOD < min_sample_period(CLK_DIV)) begin : g_bad_period
    $error("SAMPLE_PERIOD too short for CLK_DIV");
  end
  if (ADC_BITS + LEAD_BITS != FRAME_BITS) begin : g_bad_width
    $error("ADC_BITS + LEAD_BITS must equal FRAME_BITS");
  end

  state_e              state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                abort_q, abort_d;
  logic                cs_n_q, cs_n_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADC_BITS-1:0] v_therm_q, v_therm_d;
  logic                v_valid_q, v_valid_d;
  logic                frame_err_q, frame_err_d;

  logic                  rx_start, rx_done;
  logic [FRAME_BITS-1:0] rx_frame;
  logic                  lead_bad;
  logic [ADC_BITS-1:0]   rx_data;

  assign lead_bad = |rx_frame[FRAME_BITS-1 -: LEAD_BITS];
  assign rx_data  = rx_frame[ADC_BITS-1:0];

  spi_frame_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (rx_start),
    .miso_i  (adc_miso_i),
    .sclk_o  (adc_sclk_o),
    .done_o  (rx_done),
    .frame_o (rx_frame)
  );

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    tmr_d       = tmr_q;
    abort_d     = abort_q;
    cs_n_d      = cs_n_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    v_therm_d   = v_therm_q;
    v_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    rx_start    = 1'b0;

    if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
    if (ph_q != '0)  ph_d  = ph_q - 1'b1;
    // enable dropping while CS_n is low marks the frame for discard
    if (state_q inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD} && !enable_i) abort_d = 1'b1;

    if (cnt_q == CNT_FULL) begin
      v_therm_d = acc_q[ACC_W-1:AVG_LOG2];
      v_valid_d = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_CS_SETUP;
          cs_n_d  = 1'b0;
          ph_d    = PH_LAST;
          tmr_d   = T_LAST;
          abort_d = 1'b0;
        end
      end
      ST_CS_SETUP: begin
        if (ph_q == '0) begin
          rx_start = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rx_done) begin
          state_d = ST_CS_HOLD;
          ph_d    = PH_LAST;
        end
      end
      ST_CS_HOLD: begin
        if (ph_q == '0) begin
          state_d     = ST_ACCUM;
          cs_n_d      = 1'b1;
          frame_err_d = lead_bad && !abort_d;
        end
      end
      ST_ACCUM: begin
        if (abort_q) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_WAIT;
          if (!lead_bad) begin
            acc_d = acc_q + ACC_W'(rx_data);
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (tmr_q == '0) begin
          if (enable_i) begin
            state_d = ST_CS_SETUP;
            cs_n_d  = 1'b0;
            ph_d    = PH_LAST;
            tmr_d   = T_LAST;
            abort_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      tmr_q       <= '0;
      abort_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      v_therm_q   <= '0;
      v_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      tmr_q       <= tmr_d;
      abort_q     <= abort_d;
      cs_n_q      <= cs_n_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      v_therm_q   <= v_therm_d;
      v_valid_q   <= v_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign adc_cs_n_o  = cs_n_q;
  assign v_therm_o   = v_therm_q;
  assign v_valid_o   = v_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_therm_adc_reader.sv
// Bench for therm_adc_reader: serial ADC model plus a frame-level averaging
// reference; protocol timing and outputs are checked at negedge.
`timescale 1ns/1ps
module tb_therm_adc_reader;

  localparam int CLK_DIV       = 4;
  localparam int ADC_BITS      = 12;
  localparam int AVG_LOG2      = 2;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int CONV_CYC      = 34 * CLK_DIV;
  localparam int AVG_N         = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic miso = 1'b0;
  logic cs_n, sclk, v_valid, frame_err, busy;
  logic [ADC_BITS-1:0] v_therm;

  therm_adc_reader #(
    .CLK_DIV(CLK_DIV), .ADC_BITS(ADC_BITS), .AVG_LOG2(AVG_LOG2), .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .adc_cs_n_o(cs_n), .adc_sclk_o(sclk), .adc_miso_i(miso),
    .v_therm_o(v_therm), .v_valid_o(v_valid), .frame_err_o(frame_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ADC model: shifts the next word out MSB first, updating on SCLK fall
  logic [15:0] word_q[$];
  logic [15:0] cur_word = 16'h0;
  int adc_rises = 0;

  always @(negedge cs_n) begin
    cur_word  = (word_q.size() != 0) ? word_q.pop_front() : 16'h0000;
    adc_rises = 0;
    miso      = cur_word[15];
  end
  always @(posedge sclk) if (cs_n === 1'b0) adc_rises++;
  always @(negedge sclk) if (cs_n === 1'b0 && adc_rises < 16) miso = cur_word[15 - adc_rises];

  // Reference: frames in arrival order, averaged in groups of AVG_N
  logic [ADC_BITS-1:0] avg_list[$];
  logic [ADC_BITS-1:0] exp_v  = '0;
  logic [ADC_BITS-1:0] last_v = '0;
  logic err_pend = 1'b0;
  logic val_due  = 1'b0;
  int n_exp_valid = 0, n_exp_err = 0, n_valid = 0, n_err = 0;

  task automatic model_frame(input logic [15:0] w, input logic ab);
    int sum;
    if (ab) avg_list.delete();
    else if (w[15:12] != 4'h0) begin
      err_pend = 1'b1;
      n_exp_err++;
    end else begin
      avg_list.push_back(w[11:0]);
      if (avg_list.size() == AVG_N) begin
        sum = 0;
        foreach (avg_list[i]) sum += int'(avg_list[i]);
        exp_v   = ADC_BITS'(sum / AVG_N);
        val_due = 1'b1;
        n_exp_valid++;
        avg_list.delete();
      end
    end
  endtask

  logic mon_on = 1'b0, cs_prev = 1'b1, sclk_prev = 1'b1;
  logic have_fall = 1'b0, busy_gap = 1'b1, aborted = 1'b0;
  int cyc_f = 0, cyc_r = 1000, cyc_p = 0, mon_rises = 0;
  int frames_started = 0, frames_done = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      cyc_f++; cyc_r++; cyc_p++;
      if (!busy) busy_gap = 1'b1;
      if (cs_prev && !cs_n) begin
        if (have_fall && !busy_gap) check("period", cyc_p, SAMPLE_PERIOD);
        have_fall = 1'b1; busy_gap = 1'b0;
        cyc_f = 0; cyc_p = 0; mon_rises = 0; aborted = 1'b0;
        frames_started++;
      end
      if (!cs_n && !enable) aborted = 1'b1;
      if (!cs_n && !sclk_prev && sclk) begin
        mon_rises++;
        if (mon_rises == 1) check("first_sample", cyc_f, 2 * CLK_DIV);
      end
      if (!cs_prev && cs_n) begin
        check("cs_low_len", cyc_f, CONV_CYC);
        check("sclk_rises", mon_rises, 16);
        frames_done++;
        cyc_r = 0;
        model_frame(cur_word, aborted);
      end
      if (frame_err) n_err++;
      if (frame_err || err_pend) begin
        check("frame_err", frame_err, err_pend);
        if (frame_err) check("frame_err_time", cyc_r, 0);
        err_pend = 1'b0;
      end
      if (v_valid) n_valid++;
      if (cyc_r == 2 && (val_due || v_valid)) begin
        check("v_valid", v_valid, val_due);
        if (val_due) begin
          check("v_therm", v_therm, exp_v);
          last_v = exp_v;
        end
        val_due = 1'b0;
      end else if (v_valid) check("v_valid_time", cyc_r, 2);
    end
    cs_prev   = cs_n;
    sclk_prev = sclk;
  end

  task automatic wait_done(input int n, input string tag);
    int c = 0;
    while (frames_done < n && c < 40000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(tag, frames_done, n);
  endtask

  initial begin
    logic [15:0] w;
    int c;
    int quiet_bad;

    repeat (8) word_q.push_back(16'h0ABC);
    word_q.push_back(16'd100); word_q.push_back(16'd101);
    word_q.push_back(16'd102); word_q.push_back(16'd103);
    repeat (4) word_q.push_back(16'h0FFF);
    word_q.push_back(16'h0200); word_q.push_back(16'h8123);
    repeat (3) word_q.push_back(16'h0200);
    word_q.push_back(16'h0100); word_q.push_back(16'h0300); word_q.push_back(16'h0500);
    word_q.push_back(16'h0010); word_q.push_back(16'h0020);
    word_q.push_back(16'h0030); word_q.push_back(16'h0041);
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom_range(0, 4095));
      if ($urandom_range(0, 5) == 0) w[15:12] = 4'($urandom_range(1, 15));
      word_q.push_back(w);
    end

    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_v_therm", v_therm, 0);
    check("rst_v_valid", v_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_cs_n", cs_n, 1);

    mon_on = 1'b1;
    enable = 1'b1;
    wait_done(23, "frames_pre_abort");

    c = 0;
    while (!(frames_started == 24 && mon_rises >= 8) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("abort_point", mon_rises, 8);
    enable = 1'b0;
    c = 0;
    while (busy && c < 500) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("abort_busy_fall", busy, 0);
    check("abort_frame_done", frames_done, 24);
    repeat (50) @(posedge clk);
    #1;
    check("abort_idle_cs", cs_n, 1);
    check("abort_v_therm_hold", v_therm, last_v);

    enable = 1'b1;
    wait_done(36, "frames_total");
    repeat (5) @(posedge clk);
    #1;
    check("v_valid_count", n_valid, n_exp_valid);
    check("frame_err_count", n_err, n_exp_err);
    check("v_therm_hold", v_therm, last_v);

    mon_on = 1'b0;
    c = 0;
    while (!(cs_n == 1'b0 && adc_rises >= 5) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("rst_mid_shift_reached", (cs_n == 1'b0 && adc_rises >= 5), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_cs_n", cs_n, 1);
    check("rst_mid_sclk", sclk, 1);
    check("rst_mid_v_therm", v_therm, 0);
    check("rst_mid_busy", busy, 0);
    quiet_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk !== 1'b1) quiet_bad++;
    end
    check("rst_sclk_quiet", quiet_bad, 0);
    rst = 1'b0;
    enable = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
